// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter block with return stack.
package pc_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned PTR_W         = $clog2(DEFAULT_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BRANCH,
    OP_CALL,
    OP_RET,
    OP_LOAD
  } pc_op_t;

  // Collapses the raw control strobes into the single action taken this cycle.
  function automatic pc_op_t resolve_op(
    input logic enable,
    input logic ret,
    input logic call,
    input logic branch,
    input logic inc
  );
    pc_op_t op;
    if (enable)      op = OP_LOAD;
    else if (ret)    op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (branch) op = OP_BRANCH;
    else if (inc)    op = OP_INC;
    else             op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_register_return_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest entry.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top,
  output logic                  empty,
  output logic                  full,
  output logic                  err
);

  localparam int unsigned SP_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]       r_sp;
  logic [SP_W:0]         r_count;
  logic                  r_err;
  logic                  w_empty;
  logic                  w_full;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (SP_W+1)'(DEPTH));

  // r_sp is the next write slot, so the top entry sits one below it.
  assign top   = r_mem[r_sp - SP_W'(1)];
  assign empty = w_empty;
  assign full  = w_full;
  assign err   = r_err;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_sp    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (pop) begin
      if (w_empty) begin
        r_err <= 1'b1;
      end else begin
        r_sp    <= r_sp - SP_W'(1);
        r_count <= r_count - (SP_W+1)'(1);
      end
    end else if (push) begin
      r_sp <= r_sp + SP_W'(1);
      if (w_full) r_err   <= 1'b1;
      else        r_count <= r_count + (SP_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !pop && !clear) r_mem[r_sp] <= push_data;
  end

endmodule

// File: rtl/pc_stack_register.sv
// Program counter with load, step increment, relative branch and call/return stack.
module pc_stack_register
  import pc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] INIT         = '0,
  parameter int unsigned           STEP         = 1,
  parameter int unsigned           OFFSET_WIDTH = 19,
  parameter int unsigned           DEPTH        = DEFAULT_DEPTH
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    inc,
  input  logic                    branch,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic                    call,
  input  logic                    ret,
  input  logic [DATA_WIDTH-1:0]   BusMuxOut,
  output logic [DATA_WIDTH-1:0]   BusMuxIn,
  output logic                    stack_empty,
  output logic                    stack_full,
  output logic                    stack_err
);

  logic [DATA_WIDTH-1:0] r_pc = INIT;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic [DATA_WIDTH-1:0] w_pc_step;
  logic [DATA_WIDTH-1:0] w_offset_ext;
  logic [DATA_WIDTH-1:0] w_top;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  pc_op_t                w_op;

  assign w_op         = resolve_op(enable, ret, call, branch, inc);
  assign w_pc_step    = r_pc + DATA_WIDTH'(STEP);
  assign w_offset_ext = {{(DATA_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
  assign w_push       = (w_op == OP_CALL);
  assign w_pop        = (w_op == OP_RET);

  always_comb begin
    w_pc_next = r_pc;
    unique case (w_op)
      OP_LOAD:   w_pc_next = BusMuxOut;
      OP_RET:    w_pc_next = w_empty ? r_pc : w_top;
      OP_CALL:   w_pc_next = BusMuxOut;
      OP_BRANCH: w_pc_next = r_pc + w_offset_ext;
      OP_INC:    w_pc_next = w_pc_step;
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) r_pc <= INIT;
    else       r_pc <= w_pc_next;
  end

  return_stack #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_return_stack (
    .clock     (clock),
    .clear     (clear),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_step),
    .top       (w_top),
    .empty     (w_empty),
    .full      (stack_full),
    .err       (stack_err)
  );

  assign BusMuxIn    = r_pc;
  assign stack_empty = w_empty;

endmodule

// File: tb/tb_pc_stack_register.sv
// Directed checks of the PC register and its return stack with hand-computed expectations.
module tb_pc_stack_register;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic        inc = 1'b0;
  logic        branch = 1'b0;
  logic [18:0] offset = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic [31:0] BusMuxIn;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pc_stack_register #(
    .DATA_WIDTH   (32),
    .INIT         (32'h0000_0000),
    .STEP         (1),
    .OFFSET_WIDTH (19),
    .DEPTH        (4)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .enable      (enable),
    .inc         (inc),
    .branch      (branch),
    .offset      (offset),
    .call        (call),
    .ret         (ret),
    .BusMuxOut   (BusMuxOut),
    .BusMuxIn    (BusMuxIn),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; enable = 1'b0; inc = 1'b0; branch = 1'b0;
    call = 1'b0; ret = 1'b0;
  endtask

  task automatic load(input logic [31:0] v);
    idle(); enable = 1'b1; BusMuxOut = v;
    step();
    idle();
  endtask

  task automatic do_call(input logic [31:0] target);
    idle(); call = 1'b1; BusMuxOut = target;
    step();
    idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1'b1;
    step();
    idle();
  endtask

  task automatic do_clear();
    idle(); clear = 1'b1;
    step();
    idle();
  endtask

  logic [31:0] exp_ret [4];

  initial begin
    #2;
    do_clear();
    check("reset_pc", BusMuxIn, 32'h0);
    check("reset_empty", {31'b0, stack_empty}, 32'd1);
    check("reset_full", {31'b0, stack_full}, 32'd0);
    check("reset_err", {31'b0, stack_err}, 32'd0);

    inc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("inc_seq", BusMuxIn, 32'(i));
    end
    idle();
    check("inc_empty", {31'b0, stack_empty}, 32'd1);
    check("inc_err", {31'b0, stack_err}, 32'd0);

    load(32'h100);
    check("load", BusMuxIn, 32'h100);
    branch = 1'b1; offset = 19'h7FFFC;
    step();
    check("branch_neg", BusMuxIn, 32'hFC);
    offset = 19'h00010;
    step();
    check("branch_pos", BusMuxIn, 32'h10C);
    idle();
    load(32'h100);
    branch = 1'b1; inc = 1'b1; offset = 19'h7FE00;
    step();
    idle();
    check("branch_wrap_over_inc", BusMuxIn, 32'hFFFF_FF00);
    load(32'hFFFF_FFFF);
    inc = 1'b1;
    step();
    idle();
    check("inc_wrap", BusMuxIn, 32'h0);

    load(32'h20);
    do_call(32'h400);
    check("call_pc", BusMuxIn, 32'h400);
    check("call_empty", {31'b0, stack_empty}, 32'd0);
    do_ret();
    check("ret_pc", BusMuxIn, 32'h21);
    check("ret_empty", {31'b0, stack_empty}, 32'd1);

    load(32'h0);
    for (int i = 1; i <= 5; i++) begin
      do_call(32'(i * 16));
      check("call_chain_pc", BusMuxIn, 32'(i * 16));
      if (i == 4) begin
        check("full_at_4", {31'b0, stack_full}, 32'd1);
        check("no_err_at_4", {31'b0, stack_err}, 32'd0);
      end
    end
    check("full_after_5", {31'b0, stack_full}, 32'd1);
    check("err_after_5", {31'b0, stack_err}, 32'd1);
    exp_ret[0] = 32'h41; exp_ret[1] = 32'h31; exp_ret[2] = 32'h21; exp_ret[3] = 32'h11;
    for (int i = 0; i < 4; i++) begin
      do_ret();
      check("ret_chain_pc", BusMuxIn, exp_ret[i]);
    end
    check("ret_chain_empty", {31'b0, stack_empty}, 32'd1);
    check("ret_chain_full", {31'b0, stack_full}, 32'd0);

    do_clear();
    load(32'h55);
    do_ret();
    check("underflow_pc", BusMuxIn, 32'h55);
    check("underflow_err", {31'b0, stack_err}, 32'd1);
    inc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("err_sticky", {31'b0, stack_err}, 32'd1);
    end
    idle();
    check("pc_after_incs", BusMuxIn, 32'h5F);
    do_clear();
    check("clear_err", {31'b0, stack_err}, 32'd0);
    check("clear_pc", BusMuxIn, 32'h0);

    do_call(32'h200);
    check("single_call_pc", BusMuxIn, 32'h200);
    enable = 1'b1; call = 1'b1; inc = 1'b1; BusMuxOut = 32'h77;
    step();
    idle();
    check("load_wins_pc", BusMuxIn, 32'h77);
    check("load_wins_full", {31'b0, stack_full}, 32'd0);
    ret = 1'b1; call = 1'b1; BusMuxOut = 32'h999;
    step();
    idle();
    check("ret_over_call_pc", BusMuxIn, 32'h1);
    check("ret_over_call_empty", {31'b0, stack_empty}, 32'd1);
    do_call(32'h300);
    do_ret();
    check("slot_reuse_pc", BusMuxIn, 32'h2);
    check("slot_reuse_err", {31'b0, stack_err}, 32'd0);

    do_call(32'h500);
    clear = 1'b1; call = 1'b1; BusMuxOut = 32'h600;
    step();
    idle();
    check("clear_call_pc", BusMuxIn, 32'h0);
    check("clear_call_empty", {31'b0, stack_empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_register.md
Name: pc_stack_register

Overview:
Parametrised program-counter register, the successor to the basic PC block.
- Keeps the absolute-load and increment behaviour.
- Adds a programmable increment step, PC-relative branching, and a hardware return-address stack for call/return.
- Sits on the datapath bus: loads from BusMuxOut, drives BusMuxIn, and is controlled directly by the control unit.

Parameters:
DATA_WIDTH, 32, width of PC and bus.
INIT, 32'h00000000, PC value after clear and at power-up.
STEP, 1, increment amount applied on inc and used to form the return address.
OFFSET_WIDTH, 19, width of the signed branch offset.
DEPTH, 4, return-stack entries; must be a power of two and >= 2.

Ports:
clock  in  1  rising-edge clock, the only clock.
clear  in  1  synchronous active-high reset.
enable  in  1  load PC from BusMuxOut.
inc  in  1  PC <= PC + STEP.
branch  in  1  PC <= PC + sext(offset).
offset  in  OFFSET_WIDTH  signed two's-complement branch offset.
call  in  1  push PC+STEP onto the stack; PC <= BusMuxOut.
ret  in  1  PC <= top of stack; pop.
BusMuxOut  in  DATA_WIDTH  bus value for load/call target.
BusMuxIn  out  DATA_WIDTH  current PC.
stack_empty  out  1  no valid entries.
stack_full  out  1  DEPTH valid entries.
stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high, named clear.
- Clear (sampled on the rising edge):
  - PC = INIT.
  - Stack pointer = 0, count = 0.
  - stack_empty = 1, stack_full = 0, stack_err = 0.
  - Stack RAM contents are don't-care.
- Power-up: PC initialised to INIT.
- Command priority per cycle, one action only: clear > enable > ret > call > branch > inc > hold. Lower-priority requests in the same cycle are ignored with no side effects (no push, no pop, no flag change).
- Latency: every update lands on the next rising edge. BusMuxIn is the registered PC; there is no combinational path from inputs to BusMuxIn.
- Arithmetic:
  - All PC arithmetic is modulo 2^DATA_WIDTH, wrapping silently.
  - offset is sign-extended to DATA_WIDTH before adding.
  - The return address is PC + STEP, computed from the PC value before the update.
- Call:
  - Writes PC+STEP at the write pointer, advances the pointer, and increments count (saturating at DEPTH).
  - If the stack is already full: the oldest entry is overwritten (circular buffer), count stays DEPTH, and stack_err is set.
  - The PC still loads BusMuxOut.
- Ret:
  - If count > 0: PC = top entry, pointer decrements, count decrements.
  - If count == 0: PC holds, the pointer is unchanged, and stack_err is set.
- stack_err stays set until clear.
- stack_empty and stack_full are registered-state decodes of count; they are valid in the same cycle the count changes becomes visible.
- Back-to-back operations:
  - call then ret on consecutive cycles returns the pushed address.
  - ret followed immediately by call reuses the freed slot.
- Clear asserted together with any command: clear wins and the stack is emptied.

Decomposition:
- Package pc_pkg holds:
  - the localparam PTR_W = $clog2(DEPTH);
  - an enum pc_op_t {OP_HOLD, OP_INC, OP_BRANCH, OP_CALL, OP_RET, OP_LOAD};
  - a function that resolves the priority of the raw strobes into pc_op_t.
- Sub-module return_stack (params DATA_WIDTH, DEPTH):
  - ports clock, clear, push, pop, push_data, top, empty, full, err;
  - circular LIFO with count.
- The top level holds the PC register, the adder/mux, and the operation decode.

Test Plan:
- Clear then 3x inc (STEP=1, INIT=0) -> BusMuxIn 0,1,2,3 on successive edges; stack_empty=1, stack_err=0.
- PC=0x100, branch with offset=-4 (0x7FFFC) -> PC=0xFC; then offset=+0x10 -> PC=0x10C; PC=0xFFFFFFFF with inc -> 0x00000000.
- PC=0x20, call with BusMuxOut=0x400 -> PC=0x400, stack top=0x21, stack_empty=0; then ret -> PC=0x21, stack_empty=1.
- 5 calls with DEPTH=4, targets 0x10..0x50 from PC=0 -> stack_full=1 and stack_err=1 after the 5th; 4 rets return addresses of calls 5,4,3,2, then stack_empty=1.
- ret on an empty stack with PC=0x55 -> PC stays 0x55, stack_err=1; the flag persists across 10 cycles of inc; clear -> stack_err=0, PC=INIT.
- enable+call+inc in the same cycle with BusMuxOut=0x77 -> PC=0x77 and stack unchanged; clear+call together -> PC=INIT, stack_empty=1.
